parity_check_rx: RTL

Downstream consumer of the 4-bit even-parity generator stage (inputs a,b,c,d; parity output e). Receives the generator's frame serially (a, b, c, d, then parity e) and re-assembles the nibble. Recomputes parity and flags mismatches. Presents each checked frame on a one-entry valid/ready output buffer with error and overrun bookkeeping.

---
 rtl/parity_pkg.sv | 18 +
 rtl/parity_calc4.sv | 17 +
 rtl/parity_check_rx.sv | 127 ++++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the 4-bit parity generator / checker pair.
//   FRAME_DATA_BITS : payload bits per frame (a, b, c, d)
//   FRAME_BITS      : payload plus the trailing parity bit
//   IDX_W           : width of the receive bit index
//   state_t         : receiver FSM states
package parity_pkg;

    localparam int FRAME_DATA_BITS = 4;
    localparam int FRAME_BITS      = FRAME_DATA_BITS + 1;
    localparam int IDX_W           = $clog2(FRAME_DATA_BITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

endpackage

// File: rtl/parity_calc4.sv
// Combinational parity of a nibble, shared by the generator and checker.
// Ports:
//   nibble : data bits {a, b, c, d}
//   parity : parity bit a matching frame must carry
//            (even: a^b^c^d, odd: ~(a^b^c^d))
module parity_calc4
    import parity_pkg::*;
#(
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic [FRAME_DATA_BITS-1:0] nibble,
    output logic                       parity
);

    assign parity = (^nibble) ^ ODD_PARITY;

endmodule

// File: rtl/parity_check_rx.sv
// Serial receiver for the 4-bit parity frame: a, b, c, d, then parity.
// Re-assembles the nibble, checks parity, and presents each completed
// frame on a one-entry valid/ready buffer.
// Ports:
//   clk, rst_n   : clock; synchronous active-low reset
//   sin          : serial frame bit, sampled when sin_valid is high
//   sof          : marks bit a; restarts any frame in progress
//   data_out     : checked nibble, [3]=a .. [0]=d
//   par_err      : parity mismatch for the frame in data_out
//   out_valid    : data_out/par_err hold a frame
//   out_ready    : consumer accepts when out_valid && out_ready
//   overrun      : sticky, a completed frame was dropped (full buffer)
//   err_cnt      : saturating count of parity-failing frames
module parity_check_rx
    import parity_pkg::*;
#(
    parameter bit ODD_PARITY = 1'b0,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sin,
    input  logic                       sin_valid,
    input  logic                       sof,
    output logic [FRAME_DATA_BITS-1:0] data_out,
    output logic                       par_err,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       overrun,
    output logic [ERR_CNT_W-1:0]       err_cnt
);

    state_t                     state, state_next;
    logic [IDX_W-1:0]           bit_idx, bit_idx_next;
    logic [FRAME_DATA_BITS-1:0] shreg, shreg_next;
    logic                       frame_done;
    logic                       frame_err;
    logic                       exp_parity;

    // shreg shifts left, so after d arrives a sits in the MSB and the
    // register already matches the data_out bit order.
    parity_calc4 #(.ODD_PARITY(ODD_PARITY)) u_calc (
        .nibble (shreg),
        .parity (exp_parity)
    );

    // Only meaningful on the cycle frame_done is high (sin is the parity bit).
    assign frame_err = (sin != exp_parity);

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
        frame_done   = 1'b0;

        if (sin_valid && sof) begin
            // Restart from any state; a partial frame is dropped silently.
            state_next   = DATA;
            bit_idx_next = IDX_W'(1);
            shreg_next   = {{(FRAME_DATA_BITS-1){1'b0}}, sin};
        end else if (sin_valid) begin
            case (state)
                DATA: begin
                    shreg_next = {shreg[FRAME_DATA_BITS-2:0], sin};
                    if (bit_idx == IDX_W'(FRAME_DATA_BITS-1)) begin
                        state_next   = PAR;
                        bit_idx_next = '0;
                    end else begin
                        bit_idx_next = bit_idx + IDX_W'(1);
                    end
                end
                PAR: begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end
                default: ;  // IDLE: stray bits without sof are ignored
            endcase
        end
    end

    // NOTE: reset is synchronous -- it is just the highest-priority branch
    // inside the clocked block, with no reset term in the sensitivity list.
    // NOTE: registers are written with <= so every flop samples the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_next;
            bit_idx <= bit_idx_next;
            shreg   <= shreg_next;
        end
    end

    // Output buffer, overrun flag and error counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out  <= '0;
            par_err   <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            if (frame_done) begin
                // A consumer taking the old frame on this edge frees the slot.
                if (!out_valid || out_ready) begin
                    data_out  <= shreg;
                    par_err   <= frame_err;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
                // Dropped frames still count toward the error total.
                if (frame_err && (err_cnt != '1)) begin
                    err_cnt <= err_cnt + ERR_CNT_W'(1);
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
